// File: rtl/ddr4_open_page_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr4_open_page_scheduler_if
// Description : Request and DRAM command bus bundle for the open-page
//               DDR4 scheduler. The master is the request source and command
//               sink; the slave is the scheduler itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr4_open_page_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [13:0] cmd_row;
    logic [10:0] cmd_col;
    logic        done;
    logic [1:0]  done_stat;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
        input  done, done_stat
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
        output done, done_stat
    );
endinterface
`default_nettype wire

// File: rtl/ddr4_open_page_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ddr4_open_page_scheduler
// Description : In-order DDR4 command scheduler with an open-page policy.
//               Issues PRE/ACT/RD/WR for one request at a time, tracks the
//               open row of 16 banks and enforces tRCD/tRP/tRAS/tWR/tCCD_L.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr4_open_page_scheduler #(
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RAS   = 52,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4,
    parameter int T_WR    = 20,
    parameter int T_CCD_L = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ddr4_open_page_scheduler_if.slave  bus
);

    // All timing values must fit in this counter width.
    localparam int c_CNT_W = 8;
    typedef logic [c_CNT_W-1:0] cnt_t;

    localparam cnt_t c_T_RCD   = cnt_t'(T_RCD);
    localparam cnt_t c_T_RP    = cnt_t'(T_RP);
    localparam cnt_t c_T_RAS   = cnt_t'(T_RAS);
    localparam cnt_t c_T_CCD_L = cnt_t'(T_CCD_L);
    localparam cnt_t c_T_WRREC = cnt_t'(T_CWL + T_BURST + T_WR);

    localparam logic [2:0] c_CMD_ACT = 3'd1;
    localparam logic [2:0] c_CMD_PRE = 3'd2;
    localparam logic [2:0] c_CMD_RD  = 3'd3;
    localparam logic [2:0] c_CMD_WR  = 3'd4;

    localparam logic [1:0] c_STAT_HIT      = 2'd0;
    localparam logic [1:0] c_STAT_MISS     = 2'd1;
    localparam logic [1:0] c_STAT_CONFLICT = 2'd2;

    localparam logic [1:0] c_OP_WR = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_PRE    = 3'd2,
        S_ACT    = 3'd3,
        S_CAS    = 3'd4
    } state_t;

    function automatic cnt_t dec_sat(input cnt_t v);
        return (v == '0) ? '0 : v - cnt_t'(1);
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] row_lat_q, row_lat_d;
    logic [10:0] col_lat_q, col_lat_d;
    logic [3:0]  bank_lat_q, bank_lat_d;
    logic [1:0]  stat_q, stat_d;

    logic [15:0] open_q, open_d;
    logic [13:0] row_q [16];
    logic [13:0] row_d [16];
    cnt_t        tras_q [16];
    cnt_t        tras_d [16];
    cnt_t        twr_q  [16];
    cnt_t        twr_d  [16];
    cnt_t        trcd_q, trcd_d;
    cnt_t        trp_q, trp_d;
    cnt_t        ccd_q, ccd_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_type_q, cmd_type_d;
    logic [1:0]  cmd_bg_q, cmd_bg_d;
    logic [1:0]  cmd_ba_q, cmd_ba_d;
    logic [13:0] cmd_row_q, cmd_row_d;
    logic [10:0] cmd_col_q, cmd_col_d;
    logic        done_q, done_d;
    logic [1:0]  done_stat_q, done_stat_d;

    // DECODE is folded into the first cycle of its target phase so that a
    // hit (or the first ACT/PRE) can appear on the bus two cycles after
    // acceptance.
    state_t      w_phase;
    logic [1:0]  w_stat_now;

    // Address bits [2:0] are byte offset within the burst word.
    logic        w_unused_addr;
    assign w_unused_addr = ^bus.req_addr[2:0];

    // Next-state, command selection and timing counter updates.
    // Every gate checks the counter value it will hold in the cycle the
    // command becomes visible, so a load of N permits the next command
    // exactly N cycles later.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        row_lat_d   = row_lat_q;
        col_lat_d   = col_lat_q;
        bank_lat_d  = bank_lat_q;
        stat_d      = stat_q;
        open_d      = open_q;
        row_d       = row_q;
        trcd_d      = dec_sat(trcd_q);
        trp_d       = dec_sat(trp_q);
        ccd_d       = dec_sat(ccd_q);
        for (int i = 0; i < 16; i++) begin
            tras_d[i] = dec_sat(tras_q[i]);
            twr_d[i]  = dec_sat(twr_q[i]);
        end
        cmd_valid_d = 1'b0;
        cmd_type_d  = '0;
        cmd_bg_d    = '0;
        cmd_ba_d    = '0;
        cmd_row_d   = '0;
        cmd_col_d   = '0;
        done_d      = 1'b0;
        done_stat_d = '0;
        w_phase     = state_q;
        w_stat_now  = stat_q;

        if (state_q == S_DECODE) begin
            if (open_q[bank_lat_q] && (row_q[bank_lat_q] == row_lat_q)) begin
                w_phase    = S_CAS;
                w_stat_now = c_STAT_HIT;
            end else if (!open_q[bank_lat_q]) begin
                w_phase    = S_ACT;
                w_stat_now = c_STAT_MISS;
            end else begin
                w_phase    = S_PRE;
                w_stat_now = c_STAT_CONFLICT;
            end
            state_d = w_phase;
            stat_d  = w_stat_now;
        end

        case (w_phase)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d       = bus.req_op;
                    row_lat_d  = bus.req_addr[31:18];
                    col_lat_d  = {bus.req_addr[17:10], bus.req_addr[5:3]};
                    bank_lat_d = {bus.req_addr[7:6], bus.req_addr[9:8]};
                    state_d    = S_DECODE;
                end
            end
            S_PRE: begin
                if ((tras_d[bank_lat_q] == '0) && (twr_d[bank_lat_q] == '0)) begin
                    cmd_valid_d          = 1'b1;
                    cmd_type_d           = c_CMD_PRE;
                    cmd_bg_d             = bank_lat_q[3:2];
                    cmd_ba_d             = bank_lat_q[1:0];
                    open_d[bank_lat_q]   = 1'b0;
                    trp_d                = c_T_RP;
                    state_d              = S_ACT;
                end
            end
            S_ACT: begin
                if (trp_d == '0) begin
                    cmd_valid_d          = 1'b1;
                    cmd_type_d           = c_CMD_ACT;
                    cmd_bg_d             = bank_lat_q[3:2];
                    cmd_ba_d             = bank_lat_q[1:0];
                    cmd_row_d            = row_lat_q;
                    open_d[bank_lat_q]   = 1'b1;
                    row_d[bank_lat_q]    = row_lat_q;
                    tras_d[bank_lat_q]   = c_T_RAS;
                    trcd_d               = c_T_RCD;
                    state_d              = S_CAS;
                end
            end
            S_CAS: begin
                if ((trcd_d == '0) && (ccd_d == '0)) begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = (op_q == c_OP_WR) ? c_CMD_WR : c_CMD_RD;
                    cmd_bg_d    = bank_lat_q[3:2];
                    cmd_ba_d    = bank_lat_q[1:0];
                    cmd_col_d   = col_lat_q;
                    ccd_d       = c_T_CCD_L;
                    if (op_q == c_OP_WR) begin
                        twr_d[bank_lat_q] = c_T_WRREC;
                    end
                    done_d      = 1'b1;
                    done_stat_d = w_stat_now;
                    state_d     = S_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    // State, bank table, counters and registered command bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            row_lat_q   <= '0;
            col_lat_q   <= '0;
            bank_lat_q  <= '0;
            stat_q      <= '0;
            open_q      <= '0;
            trcd_q      <= '0;
            trp_q       <= '0;
            ccd_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                row_q[i]  <= '0;
                tras_q[i] <= '0;
                twr_q[i]  <= '0;
            end
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_ba_q    <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            done_q      <= 1'b0;
            done_stat_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_lat_q   <= row_lat_d;
            col_lat_q   <= col_lat_d;
            bank_lat_q  <= bank_lat_d;
            stat_q      <= stat_d;
            open_q      <= open_d;
            trcd_q      <= trcd_d;
            trp_q       <= trp_d;
            ccd_q       <= ccd_d;
            for (int i = 0; i < 16; i++) begin
                row_q[i]  <= row_d[i];
                tras_q[i] <= tras_d[i];
                twr_q[i]  <= twr_d[i];
            end
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            done_q      <= done_d;
            done_stat_q <= done_stat_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type  = cmd_type_q;
    assign bus.cmd_bg    = cmd_bg_q;
    assign bus.cmd_ba    = cmd_ba_q;
    assign bus.cmd_row   = cmd_row_q;
    assign bus.cmd_col   = cmd_col_q;
    assign bus.done      = done_q;
    assign bus.done_stat = done_stat_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_open_page_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr4_open_page_scheduler
// Description : Self-checking bench for the open-page DDR4 scheduler. A
//               timestamp model predicts when each command may appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr4_open_page_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr4_open_page_scheduler_if bus ();

    ddr4_open_page_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc; int typ; int bg; int ba; int row; int col;
    } cmd_t;
    typedef struct {
        int cyc; int stat;
    } done_t;

    cmd_t  cq[$];
    done_t dq[$];
    cmd_t  mon_c;
    done_t mon_d;
    int    nop_bad = 0;

    // Bus monitor: log every issued command and done pulse with its cycle.
    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            mon_c.cyc = cyc;
            mon_c.typ = int'(bus.cmd_type);
            mon_c.bg  = int'(bus.cmd_bg);
            mon_c.ba  = int'(bus.cmd_ba);
            mon_c.row = int'(bus.cmd_row);
            mon_c.col = int'(bus.cmd_col);
            cq.push_back(mon_c);
        end else if (bus.cmd_type != 3'd0 || bus.cmd_bg != 2'd0 || bus.cmd_ba != 2'd0 ||
                     bus.cmd_row != 14'd0 || bus.cmd_col != 11'd0) begin
            nop_bad++;
        end
        if (bus.done) begin
            mon_d.cyc  = cyc;
            mon_d.stat = int'(bus.done_stat);
            dq.push_back(mon_d);
        end
    end

    // Reference model: time of last relevant command per bank / globally.
    int m_open[16];
    int m_row[16];
    int m_act[16];
    int m_wr[16];
    int m_last_act, m_last_pre, m_last_cas;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 0; m_row[i] = 0; m_act[i] = -1000; m_wr[i] = -1000;
        end
        m_last_act = -1000; m_last_pre = -1000; m_last_cas = -1000;
    endtask

    task automatic reset_dut();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cq.delete();
        dq.delete();
        model_reset();
    endtask

    // Drive one request, predict its command sequence and check it.
    task automatic run_req(input int op, input logic [31:0] addr, input int gap,
                           output int acc, output int first_c, output int cas_c,
                           output int stat_o);
        int b, r, c, stat, t_pre, t_act, t_cas, nexp;
        int et[3], ec[3], er[3], ecl[3];
        repeat (gap) @(posedge clk);
        #1;
        acc = cyc;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_at_accept cyc=%0d: got %b want 1", cyc, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op[1:0];
        bus.req_addr  = addr;
        @(posedge clk);
        #1;
        // still valid with different content while busy: must be ignored
        bus.req_op   = 2'($urandom);
        bus.req_addr = $urandom;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        b = int'({addr[7:6], addr[9:8]});
        r = int'(addr[31:18]);
        c = int'({addr[17:10], addr[5:3]});
        nexp = 0;
        if (m_open[b] != 0 && m_row[b] == r) begin
            stat  = 0;
            t_cas = max2(acc + 2, max2(m_last_cas + 8, m_last_act + 24));
        end else if (m_open[b] == 0) begin
            stat  = 1;
            t_act = max2(acc + 2, m_last_pre + 24);
            t_cas = max2(t_act + 24, m_last_cas + 8);
            et[nexp] = 1; ec[nexp] = t_act; er[nexp] = r; ecl[nexp] = 0; nexp++;
        end else begin
            stat  = 2;
            t_pre = max2(acc + 2, max2(m_act[b] + 52, m_wr[b] + 44));
            t_act = max2(t_pre + 24, m_last_pre + 24);
            t_cas = max2(t_act + 24, m_last_cas + 8);
            et[nexp] = 2; ec[nexp] = t_pre; er[nexp] = 0; ecl[nexp] = 0; nexp++;
            et[nexp] = 1; ec[nexp] = t_act; er[nexp] = r; ecl[nexp] = 0; nexp++;
            m_last_pre = t_pre;
        end
        et[nexp] = (op == 1) ? 4 : 3; ec[nexp] = t_cas; er[nexp] = 0; ecl[nexp] = c; nexp++;
        if (stat != 0) begin
            m_act[b] = t_act; m_last_act = t_act;
        end
        m_open[b] = 1; m_row[b] = r; m_last_cas = t_cas;
        if (op == 1) m_wr[b] = t_cas;

        while (cyc < t_cas + 2) @(posedge clk);
        #1;

        n_cmp++;
        if (cq.size() !== nexp) begin
            n_bad++;
            $display("FAIL cmd_count addr=%h: got %0d want %0d", addr, cq.size(), nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                n_cmp++;
                if (cq[i].typ !== et[i] || cq[i].cyc !== ec[i] || cq[i].bg !== b / 4 ||
                    cq[i].ba !== b % 4 || cq[i].row !== er[i] || cq[i].col !== ecl[i]) begin
                    n_bad++;
                    $display("FAIL cmd[%0d] addr=%h: got typ=%0d cyc=%0d bg=%0d ba=%0d row=%0d col=%0d want typ=%0d cyc=%0d bg=%0d ba=%0d row=%0d col=%0d",
                             i, addr, cq[i].typ, cq[i].cyc, cq[i].bg, cq[i].ba, cq[i].row, cq[i].col,
                             et[i], ec[i], b / 4, b % 4, er[i], ecl[i]);
                end
            end
        end
        n_cmp++;
        if (dq.size() !== 1 || (dq.size() == 1 && (dq[0].cyc !== t_cas || dq[0].stat !== stat))) begin
            n_bad++;
            $display("FAIL done addr=%h: got n=%0d cyc=%0d stat=%0d want n=1 cyc=%0d stat=%0d",
                     addr, dq.size(), (dq.size() > 0) ? dq[0].cyc : -1,
                     (dq.size() > 0) ? dq[0].stat : -1, t_cas, stat);
        end
        first_c = (cq.size() > 0) ? cq[0].cyc : -1;
        cas_c   = (dq.size() > 0) ? dq[0].cyc : -1;
        stat_o  = (dq.size() > 0) ? dq[0].stat : -1;
        cq.delete();
        dq.delete();
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_addr  = 32'h0004_0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_type, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col} !== 35'd0) begin
            n_bad++; $display("FAIL reset_cmd: got v=%b t=%0d bg=%0d ba=%0d row=%0d col=%0d want all 0",
                              bus.cmd_valid, bus.cmd_type, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col);
        end
        n_cmp++;
        if ({bus.done, bus.done_stat} !== 3'd0) begin
            n_bad++; $display("FAIL reset_done: got %b/%0d want 0/0", bus.done, bus.done_stat);
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
        end
        cq.delete(); dq.delete(); model_reset();
    endtask

    task automatic test_miss_then_hit();
        int a1, f1, c1, s1, a2, f2, c2, s2;
        reset_dut();
        run_req(0, 32'h0004_0000, 0, a1, f1, c1, s1);
        n_cmp++;
        if (f1 - a1 !== 2 || c1 - a1 !== 26 || s1 !== 1) begin
            n_bad++; $display("FAIL miss_latency: got act+%0d rd+%0d stat=%0d want act+2 rd+26 stat=1", f1 - a1, c1 - a1, s1);
        end
        run_req(0, 32'h0004_0408, 0, a2, f2, c2, s2);
        n_cmp++;
        if (c2 - c1 !== 8 || f2 !== c2 || s2 !== 0) begin
            n_bad++; $display("FAIL hit_ccd: got gap=%0d first=%0d rd=%0d stat=%0d want gap=8 first=rd stat=0", c2 - c1, f2, c2, s2);
        end
    endtask

    task automatic test_conflict();
        int a1, f1, c1, s1, a2, f2, c2, s2;
        reset_dut();
        run_req(0, 32'h0004_0000, 0, a1, f1, c1, s1);
        run_req(0, 32'h0008_0000, 0, a2, f2, c2, s2);
        n_cmp++;
        if (f2 - f1 !== 52 || c2 - f1 !== 100 || s2 !== 2) begin
            n_bad++; $display("FAIL conflict_timing: got pre=act+%0d rd=act+%0d stat=%0d want 52 100 2", f2 - f1, c2 - f1, s2);
        end
    endtask

    task automatic test_write_recovery();
        int a, f, c, s, tw, fp;
        reset_dut();
        run_req(0, 32'h0004_0000, 0, a, f, c, s);
        run_req(1, 32'h0004_0008, 10, a, f, tw, s);
        n_cmp++;
        if (s !== 0) begin
            n_bad++; $display("FAIL wr_hit_stat: got %0d want 0", s);
        end
        run_req(0, 32'h000C_0000, 0, a, fp, c, s);
        n_cmp++;
        if (fp - tw !== 44 || s !== 2) begin
            n_bad++; $display("FAIL write_recovery: got pre=wr+%0d stat=%0d want 44 2", fp - tw, s);
        end
    endtask

    task automatic test_other_bank();
        int a, f, c, s;
        reset_dut();
        run_req(0, 32'h0004_0000, 0, a, f, c, s);
        run_req(0, 32'h0004_0040, 3, a, f, c, s);
        n_cmp++;
        if (s !== 1 || f - a !== 2) begin
            n_bad++; $display("FAIL other_bank_miss: got stat=%0d act=+%0d want 1 +2", s, f - a);
        end
        run_req(2, 32'h0004_0000, 1, a, f, c, s);
        n_cmp++;
        if (s !== 0 || f !== c) begin
            n_bad++; $display("FAIL bank0_still_open: got stat=%0d first=%0d cas=%0d want 0 first=cas", s, f, c);
        end
    endtask

    task automatic test_reset_abandon();
        int a, f, c, s, pre_e;
        reset_dut();
        run_req(0, 32'h0004_0000, 0, a, f, c, s);
        @(posedge clk);
        #1;
        a = cyc;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_addr  = 32'h0008_0000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        pre_e = max2(a + 2, max2(m_act[0] + 52, m_wr[0] + 44));
        while (cyc < pre_e + 4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got rdy=%b v=%b done=%b want 0 0 0", bus.req_ready, bus.cmd_valid, bus.done);
        end
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (cq.size() !== 1 || (cq.size() == 1 && (cq[0].typ !== 2 || cq[0].cyc !== pre_e)) || dq.size() !== 0) begin
            n_bad++; $display("FAIL abandon: got ncmd=%0d first_typ=%0d ndone=%0d want 1 cmd PRE@%0d and 0 done",
                              cq.size(), (cq.size() > 0) ? cq[0].typ : -1, dq.size(), pre_e);
        end
        cq.delete(); dq.delete(); model_reset();
        run_req(0, 32'h0004_0000, 0, a, f, c, s);
        n_cmp++;
        if (s !== 1 || f - a !== 2) begin
            n_bad++; $display("FAIL after_reset_miss: got stat=%0d act=+%0d want 1 +2", s, f - a);
        end
    endtask

    task automatic test_random();
        int a, f, c, s;
        logic [31:0] addr;
        reset_dut();
        for (int k = 0; k < 60; k++) begin
            addr        = $urandom;
            addr[31:18] = 14'($urandom_range(0, 2));
            addr[9:8]   = 2'($urandom_range(0, 1));
            addr[7:6]   = 2'($urandom_range(0, 3));
            run_req(int'($urandom_range(0, 3)), addr, int'($urandom_range(0, 4)), a, f, c, s);
        end
    endtask

    task automatic test_bus_idle();
        n_cmp++;
        if (nop_bad !== 0) begin
            n_bad++; $display("FAIL nop_fields: got %0d dirty idle cycles want 0", nop_bad);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 32'd0;
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_write_recovery();
        test_other_bank();
        test_reset_abandon();
        test_random();
        test_bus_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
